// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator for a word-wide data memory without byte enables.
module load_store_unit #(
  parameter bit          WORD_ADDR = 1'b1,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_data
);
  typedef enum logic [2:0] {IDLE, RD, MERGE_WR, WR, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr, wdata, old, rdata_q;
  logic [1:0]  size;
  logic        uns, write, mis_q;
  logic        mis_req;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] ext, keep, merged;
  assign mis_req = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign sh      = {addr[1:0], 3'b000};
  assign lane    = 16'(mem_data >> sh);
  assign ext     = size == 2'd0 ? {{24{~uns & lane[7]}}, lane[7:0]} :
                   size == 2'd1 ? {{16{~uns & lane[15]}}, lane[15:0]} : mem_data;
  // No byte enables: splice the new lane into the word read back in RD.
  assign keep    = size == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff;
  assign merged  = (old & ~(keep << sh)) | ((wdata & keep) << sh);
  assign req_ready       = state == IDLE;
  assign resp_valid      = state == RESP;
  assign resp_rdata      = state == RESP ? rdata_q : 32'h0;
  assign resp_misaligned = state == RESP && mis_q;
  assign mem_read        = state == RD;
  assign mem_write       = state == WR || state == MERGE_WR;
  assign mem_address     = (mem_read || mem_write) ? (WORD_ADDR ? {2'b00, addr[31:2]} : addr) : 32'h0;
  assign mem_write_data  = state == WR ? wdata : state == MERGE_WR ? merged : 32'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      wdata   <= '0;
      old     <= '0;
      rdata_q <= '0;
      size    <= '0;
      uns     <= 1'b0;
      write   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr    <= req_addr;
          size    <= req_size;
          uns     <= req_unsigned;
          wdata   <= req_wdata;
          write   <= req_write;
          rdata_q <= '0;
          mis_q   <= mis_req;
          cnt     <= '0;
          state   <= mis_req ? RESP : (req_write && req_size == 2'd2) ? WR : RD;
        end
        RD: if (cnt == 4'(RD_WAIT)) begin
          cnt <= '0;
          if (write) begin
            old   <= mem_data;
            state <= MERGE_WR;
          end else begin
            rdata_q <= ext;
            state   <= RESP;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
        MERGE_WR, WR: state <= RESP;
        RESP:         state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench; u0 has RD_WAIT=0, u2 has RD_WAIT=2, each with its own memory.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rdy0, rv0, mis0, mw0, mr0, rdy2, rv2, mis2, mw2, mr2;
  logic [31:0] rd0, ma0, mwd0, md0, rd2, ma2, mwd2, md2;
  logic [31:0] m0 [0:63];
  logic [31:0] m2 [0:63];
  int total = 0, bad = 0;
  typedef struct {logic [31:0] rd; logic mis; int l0; int l2; int wk; logic [31:0] a1;} exp_t;
  exp_t q[$];

  load_store_unit #(.WORD_ADDR(1'b1), .RD_WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_misaligned(mis0), .mem_address(ma0),
    .mem_write_data(mwd0), .mem_write(mw0), .mem_read(mr0), .mem_data(md0));
  load_store_unit #(.WORD_ADDR(1'b1), .RD_WAIT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_rdata(rd2), .resp_misaligned(mis2), .mem_address(ma2),
    .mem_write_data(mwd2), .mem_write(mw2), .mem_read(mr2), .mem_data(md2));

  assign md0 = mr0 ? m0[ma0[5:0]] : 32'h0;
  assign md2 = mr2 ? m2[ma2[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (mw0) m0[ma0[5:0]] <= mwd0;
    if (mw2) m2[ma2[5:0]] <= mwd2;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd);
    exp_t e;
    logic m, any, both, gm0, gm2;
    int l0, l2, wk;
    logic [31:0] g0, g2, a1;
    m = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.rd  = (m || w) ? 32'h0 : erd;
    e.mis = m;
    e.a1  = m ? 32'h0 : {2'b00, a[31:2]};
    e.l0  = m ? 1 : !w ? 2 : sz == 2'd2 ? 2 : 3;
    e.l2  = m ? 1 : !w ? 4 : sz == 2'd2 ? 2 : 5;
    e.wk  = (m || !w) ? 0 : sz == 2'd2 ? 1 : 2;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l0 = 0; l2 = 0; wk = 0; any = 0; both = 0; gm0 = 0; gm2 = 0; g0 = '0; g2 = '0; a1 = '0;
    for (int k = 1; k <= 12 && (l0 == 0 || l2 == 0); k++) begin
      @(negedge clk);
      if (k == 1) a1 = ma0;
      if (mr0 || mw0) any = 1'b1;
      if (mr0 && mw0) both = 1'b1;
      if (mw0 && wk == 0) wk = k;
      if (rv0 && l0 == 0) begin l0 = k; g0 = rd0; gm0 = mis0; end
      if (rv2 && l2 == 0) begin l2 = k; g2 = rd2; gm2 = mis2; end
    end
    e = q.pop_front();
    chk({tag, " rdata"}, g0, e.rd);
    chk({tag, " rdata_w2"}, g2, e.rd);
    chk({tag, " misaligned"}, {31'b0, gm0}, {31'b0, e.mis});
    chk({tag, " misaligned_w2"}, {31'b0, gm2}, {31'b0, e.mis});
    chk({tag, " latency"}, l0, e.l0);
    chk({tag, " latency_w2"}, l2, e.l2);
    chk({tag, " write_cycle"}, wk, e.wk);
    chk({tag, " first_addr"}, a1, e.a1);
    chk({tag, " mem_activity"}, {31'b0, any}, {31'b0, ~e.mis});
    chk({tag, " rd_wr_overlap"}, {31'b0, both}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin m0[i] = 32'h0; m2[i] = 32'h0; end
    m0[4] = 32'hDEADBEEF; m2[4] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, rdy0}, 32'h1);
    chk("rst resp_valid", {31'b0, rv0}, 32'h0);
    chk("rst mem_rw", {30'b0, mr0, mw0}, 32'h0);
    chk("rst mem_address", ma0, 32'h0);
    chk("rst mem_wdata", mwd0, 32'h0);
    chk("rst rdata", rd0, 32'h0);
    rst_n = 1'b1;
    do_req("lw10",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF);
    do_req("sw10a",  1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, 32'h0);
    do_req("lb13",   1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80);
    do_req("lbu13",  1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080);
    do_req("lhu12",  1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h000080FF);
    do_req("lh12",   1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF);
    do_req("lb10",   1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000000);
    do_req("sw10b",  1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0);
    do_req("sb11",   1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 32'h0);
    do_req("lw10b",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h1122AB44);
    do_req("sh12",   1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 32'h0);
    do_req("lw10c",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAB44);
    do_req("lb11",   1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAB);
    do_req("lhu10",  1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h0000AB44);
    do_req("lh01",   1'b0, 2'd1, 1'b0, 32'h01, 32'h0,        32'h0);
    do_req("lw02",   1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0);
    do_req("size3",  1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0);
    do_req("sh13",   1'b1, 2'd1, 1'b0, 32'h13, 32'h0000FFFF, 32'h0);
    do_req("lw10d",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAB44);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmw mem_write", {31'b0, mw0}, 32'h1);
    chk("rstmw address", ma0, 32'h4);
    chk("rstmw merged", mwd0, 32'hBEEFAB55);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmw write_drop", {31'b0, mw0}, 32'h0);
    chk("rstmw ready", {31'b0, rdy0}, 32'h1);
    chk("rstmw addr_drop", ma0, 32'h0);
    chk("rstmw read_drop_w2", {31'b0, mr2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmw mem_kept", m0[4], 32'hBEEFAB44);
    chk("rstmw mem_kept_w2", m2[4], 32'hBEEFAB44);
    do_req("lw10e",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAB44);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h1;
    chk("hold ready0", {31'b0, rdy0}, 32'h1);
    @(negedge clk);
    chk("hold ready1", {31'b0, rdy0}, 32'h0);
    chk("hold write1", {31'b0, mw0}, 32'h1);
    chk("hold addr1", ma0, 32'h8);
    chk("hold data1", mwd0, 32'h1);
    req_addr = 32'h24; req_wdata = 32'h2;
    @(negedge clk);
    chk("hold ready2", {31'b0, rdy0}, 32'h0);
    chk("hold resp2", {31'b0, rv0}, 32'h1);
    chk("hold nowrite2", {31'b0, mw0}, 32'h0);
    @(negedge clk);
    chk("hold ready3", {31'b0, rdy0}, 32'h1);
    chk("hold nowrite3", {31'b0, mw0}, 32'h0);
    @(negedge clk);
    chk("hold write4", {31'b0, mw0}, 32'h1);
    chk("hold addr4", ma0, 32'h9);
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold resp5", {31'b0, rv0}, 32'h1);
    @(negedge clk);
    chk("hold mem8", m0[8], 32'h1);
    chk("hold mem9", m0[9], 32'h2);
    chk("hold mem9_w2", m2[9], 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
